// File: rtl/boot_sequencer.sv
// Hardware bring-up sequencer: memory-domain reset, file load, core-domain reset,
// bounded run, result dump. All outputs are registered decodes of the next state.
module boot_sequencer #(
  parameter int N_DOMAINS    = 5,
  parameter int RESET_CYCLES = 1,
  parameter int LOAD_CYCLES  = 1,
  parameter int RUN_CYCLES   = 3334,
  parameter int DUMP_CYCLES  = 1,
  parameter int CNT_W        = 32
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 HALT,
  input  logic [N_DOMAINS-1:0] LOAD_MASK,
  output logic [N_DOMAINS-1:0] DOM_RESET,
  output logic [N_DOMAINS-1:0] READ_FILE,
  output logic [N_DOMAINS-1:0] WRITE_FILE,
  output logic                 RUN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT,
  output logic [CNT_W-1:0]     CYCLE_COUNT,
  output logic [2:0]           STATE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_RST  = 3'd1,
    S_LOAD     = 3'd2,
    S_CORE_RST = 3'd3,
    S_RUN      = 3'd4,
    S_DUMP     = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  localparam logic [31:0]      RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]      LOAD_LAST = 32'(LOAD_CYCLES - 1);
  localparam logic [31:0]      DUMP_LAST = 32'(DUMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LIM   = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e               state_r, state_next_s;
  logic [31:0]          phase_r, phase_next_s;
  logic [N_DOMAINS-1:0] mask_r, mask_next_s;
  logic [CNT_W-1:0]     count_r, count_next_s, count_inc_s;
  logic                 timeout_r, timeout_next_s;

  logic [N_DOMAINS-1:0] dom_reset_s, read_file_s, write_file_s;
  logic                 run_s, busy_s, done_s, timeout_out_s;
  logic [N_DOMAINS-1:0] dom_reset_r, read_file_r, write_file_r;
  logic                 run_r, busy_r, done_r, timeout_out_r;

  assign count_inc_s = count_r + CNT_ONE;

  // Next-state, phase timing, mask latch, run counter and timeout flag.
  always_comb begin
    state_next_s   = state_r;
    phase_next_s   = phase_r;
    mask_next_s    = mask_r;
    count_next_s   = count_r;
    timeout_next_s = timeout_r;
    if (ABORT) begin
      state_next_s   = S_IDLE;
      phase_next_s   = 32'd0;
      timeout_next_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_next_s   = S_MEM_RST;
            phase_next_s   = 32'd0;
            mask_next_s    = LOAD_MASK;
            count_next_s   = '0;
            timeout_next_s = 1'b0;
          end else begin
            state_next_s = state_r;
          end
        end
        S_MEM_RST: begin
          if (phase_r == RST_LAST) begin
            phase_next_s = 32'd0;
            state_next_s = S_LOAD;
          end else begin
            phase_next_s = phase_r + 32'd1;
          end
        end
        S_LOAD: begin
          if (phase_r == LOAD_LAST) begin
            phase_next_s = 32'd0;
            state_next_s = S_CORE_RST;
          end else begin
            phase_next_s = phase_r + 32'd1;
          end
        end
        S_CORE_RST: begin
          if (phase_r == RST_LAST) begin
            phase_next_s = 32'd0;
            state_next_s = S_RUN;
          end else begin
            phase_next_s = phase_r + 32'd1;
          end
        end
        S_RUN: begin
          // The halting edge is itself a completed run cycle, and wins over expiry.
          count_next_s = count_inc_s;
          if (HALT) begin
            state_next_s   = S_DUMP;
            timeout_next_s = 1'b0;
          end else if (count_inc_s == RUN_LIM) begin
            state_next_s   = S_DUMP;
            timeout_next_s = 1'b1;
          end else begin
            state_next_s = S_RUN;
          end
        end
        S_DUMP: begin
          if (phase_r == DUMP_LAST) begin
            phase_next_s = 32'd0;
            state_next_s = S_DONE;
          end else begin
            phase_next_s = phase_r + 32'd1;
          end
        end
        default: begin
          state_next_s = S_IDLE;
          phase_next_s = 32'd0;
        end
      endcase
    end
  end

  // Output decode of the upcoming state so registered outputs line up with STATE.
  always_comb begin
    dom_reset_s   = '0;
    read_file_s   = '0;
    write_file_s  = '0;
    run_s         = 1'b0;
    busy_s        = 1'b1;
    done_s        = 1'b0;
    timeout_out_s = 1'b0;
    case (state_next_s)
      S_IDLE:     busy_s       = 1'b0;
      S_MEM_RST:  dom_reset_s  = mask_next_s;
      S_LOAD:     read_file_s  = mask_next_s;
      S_CORE_RST: dom_reset_s  = ~mask_next_s;
      S_RUN:      run_s        = 1'b1;
      S_DUMP:     write_file_s = mask_next_s;
      S_DONE: begin
        busy_s        = 1'b0;
        done_s        = 1'b1;
        timeout_out_s = timeout_next_s;
      end
      default:    busy_s       = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_r       <= S_IDLE;
      phase_r       <= 32'd0;
      mask_r        <= '0;
      count_r       <= '0;
      timeout_r     <= 1'b0;
      dom_reset_r   <= '0;
      read_file_r   <= '0;
      write_file_r  <= '0;
      run_r         <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_out_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      phase_r       <= phase_next_s;
      mask_r        <= mask_next_s;
      count_r       <= count_next_s;
      timeout_r     <= timeout_next_s;
      dom_reset_r   <= dom_reset_s;
      read_file_r   <= read_file_s;
      write_file_r  <= write_file_s;
      run_r         <= run_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      timeout_out_r <= timeout_out_s;
    end
  end

  assign DOM_RESET   = dom_reset_r;
  assign READ_FILE   = read_file_r;
  assign WRITE_FILE  = write_file_r;
  assign RUN         = run_r;
  assign BUSY        = busy_r;
  assign DONE        = done_r;
  assign TIMEOUT     = timeout_out_r;
  assign CYCLE_COUNT = count_r;
  assign STATE       = state_r;

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: a default instance and a short-phase instance.
module tb_boot_sequencer;

  logic clk;
  logic rst_n_a, start_a, abort_a, halt_a;
  logic rst_n_b, start_b, abort_b, halt_b;
  logic [4:0] mask_a, mask_b;
  logic [4:0] dom_a, rd_a, wr_a, dom_b, rd_b, wr_b;
  logic run_a, busy_a, done_a, to_a, run_b, busy_b, done_b, to_b;
  logic [31:0] cnt_a, cnt_b;
  logic [2:0] st_a, st_b;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       tag;
    logic [21:0] exp;
    logic        start;
    logic        abort;
    logic        halt;
    logic [4:0]  mask;
  } ent_t;

  ent_t sb[$];

  boot_sequencer u_a (
    .CLK(clk), .RESET_n(rst_n_a), .START(start_a), .ABORT(abort_a), .HALT(halt_a),
    .LOAD_MASK(mask_a), .DOM_RESET(dom_a), .READ_FILE(rd_a), .WRITE_FILE(wr_a),
    .RUN(run_a), .BUSY(busy_a), .DONE(done_a), .TIMEOUT(to_a),
    .CYCLE_COUNT(cnt_a), .STATE(st_a)
  );

  boot_sequencer #(
    .RESET_CYCLES(3), .LOAD_CYCLES(2), .RUN_CYCLES(100), .DUMP_CYCLES(4)
  ) u_b (
    .CLK(clk), .RESET_n(rst_n_b), .START(start_b), .ABORT(abort_b), .HALT(halt_b),
    .LOAD_MASK(mask_b), .DOM_RESET(dom_b), .READ_FILE(rd_b), .WRITE_FILE(wr_b),
    .RUN(run_b), .BUSY(busy_b), .DONE(done_b), .TIMEOUT(to_b),
    .CYCLE_COUNT(cnt_b), .STATE(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] mk(input logic [2:0] st, input logic [4:0] dm,
                                     input logic [4:0] rd, input logic [4:0] wr,
                                     input logic rn, input logic by, input logic dn,
                                     input logic to);
    return {st, dm, rd, wr, rn, by, dn, to};
  endfunction

  function automatic logic [21:0] obs(input int sel);
    if (sel == 0) return {st_a, dom_a, rd_a, wr_a, run_a, busy_a, done_a, to_a};
    else          return {st_b, dom_b, rd_b, wr_b, run_b, busy_b, done_b, to_b};
  endfunction

  function automatic logic [31:0] cnt(input int sel);
    if (sel == 0) return cnt_a;
    else          return cnt_b;
  endfunction

  task automatic push(input string tag, input logic [21:0] v, input int n,
                      input logic st = 1'b0, input logic ab = 1'b0,
                      input logic hl = 1'b0, input logic [4:0] m = 5'b01011);
    ent_t e;
    e.tag = tag; e.exp = v; e.start = st; e.abort = ab; e.halt = hl; e.mask = m;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic drive(input int sel, input ent_t e);
    if (sel == 0) begin
      start_a = e.start; abort_a = e.abort; halt_a = e.halt; mask_a = e.mask;
    end else begin
      start_b = e.start; abort_b = e.abort; halt_b = e.halt; mask_b = e.mask;
    end
  endtask

  // Pop one expected cycle per falling edge, compare, then apply that entry's stimulus.
  task automatic drain(input int sel);
    ent_t e;
    logic [21:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(sel);
      n_checks++;
      assert (o === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
      n_checks++;
      assert ($onehot0({|o[18:14], |o[13:9], |o[8:4], o[3]})) else begin
        n_err++;
        $error("FAIL %s_mutex: observed dom=%b rd=%b wr=%b run=%b expected at most one active",
               e.tag, o[18:14], o[13:9], o[8:4], o[3]);
      end
      drive(sel, e);
      @(negedge clk);
    end
  endtask

  task automatic chk_cnt(input string tag, input int sel, input logic [31:0] exp);
    logic [31:0] c;
    c = cnt(sel);
    n_checks++;
    assert (c === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, c, exp);
    end
  endtask

  logic [21:0] IDLE_V, RUN_V;

  initial begin
    IDLE_V = mk(3'd0, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RUN_V  = mk(3'd4, 5'b0, 5'b0, 5'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n_a = 1'b0; start_a = 1'b0; abort_a = 1'b0; halt_a = 1'b0; mask_a = 5'b0;
    rst_n_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; halt_b = 1'b0; mask_b = 5'b0;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Default instance: full timeout run with mask 10010.
    push("a_reset", IDLE_V, 1, 1'b1, 1'b0, 1'b0, 5'b10010);
    push("a_memrst", mk(3'd1, 5'b10010, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("a_load", mk(3'd2, 5'b0, 5'b10010, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("a_corerst", mk(3'd3, 5'b01101, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("a_run", RUN_V, 3334);
    push("a_dump", mk(3'd5, 5'b0, 5'b0, 5'b10010, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("a_done", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1);
    drain(0);
    chk_cnt("a_count_timeout", 0, 32'd3334);

    // Restart from DONE with all-ones mask, then abort mid-run.
    push("a_done_restart", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1,
         1'b1, 1'b0, 1'b0, 5'b11111);
    push("a_memrst2", mk(3'd1, 5'b11111, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    drain(0);
    chk_cnt("a_count_cleared", 0, 32'd0);
    push("a_load2", mk(3'd2, 5'b0, 5'b11111, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("a_corerst_ones", mk(3'd3, 5'b0, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("a_run2", RUN_V, 5);
    drain(0);
    chk_cnt("a_count_run5", 0, 32'd5);
    push("a_run_abort", RUN_V, 1, 1'b0, 1'b1);
    push("a_abort_idle", IDLE_V, 2);
    drain(0);
    chk_cnt("a_count_held", 0, 32'd5);

    // Short-phase instance: 3/2/3/4 widths, halt on the 10th run edge, ignored START/HALT.
    push("b_reset", IDLE_V, 1, 1'b1, 1'b0, 1'b0, 5'b10010);
    push("b_memrst", mk(3'd1, 5'b10010, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("b_memrst", mk(3'd1, 5'b10010, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1,
         1'b1, 1'b0, 1'b0, 5'b00111);
    push("b_memrst", mk(3'd1, 5'b10010, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("b_load", mk(3'd2, 5'b0, 5'b10010, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1,
         1'b0, 1'b0, 1'b1);
    push("b_load", mk(3'd2, 5'b0, 5'b10010, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    push("b_corerst", mk(3'd3, 5'b01101, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b_run", RUN_V, 9);
    push("b_run_halt", RUN_V, 1, 1'b0, 1'b0, 1'b1);
    push("b_dump", mk(3'd5, 5'b0, 5'b0, 5'b10010, 1'b0, 1'b1, 1'b0, 1'b0), 4);
    push("b_done_halt", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    drain(1);
    chk_cnt("b_count_halt10", 1, 32'd10);

    // HALT on the expiry edge: halt wins, no timeout.
    push("b_done_restart", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1,
         1'b1, 1'b0, 1'b0, 5'b10010);
    push("b2_memrst", mk(3'd1, 5'b10010, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b2_load", mk(3'd2, 5'b0, 5'b10010, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 2);
    push("b2_corerst", mk(3'd3, 5'b01101, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b2_run", RUN_V, 99);
    push("b2_run_halt", RUN_V, 1, 1'b0, 1'b0, 1'b1);
    push("b2_dump", mk(3'd5, 5'b0, 5'b0, 5'b10010, 1'b0, 1'b1, 1'b0, 1'b0), 4);
    push("b2_done_no_to", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1);
    drain(1);
    chk_cnt("b2_count_edge", 1, 32'd100);

    // All-zero mask, no HALT: full phase lengths with silent strobes, then timeout.
    push("b3_done_restart", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0), 1,
         1'b1, 1'b0, 1'b0, 5'b00000);
    push("b3_memrst", mk(3'd1, 5'b0, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b3_load", mk(3'd2, 5'b0, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 2);
    push("b3_corerst", mk(3'd3, 5'b11111, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b3_run", RUN_V, 100);
    push("b3_dump", mk(3'd5, 5'b0, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 4);
    push("b3_done_to", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1);
    drain(1);
    chk_cnt("b3_count_to", 1, 32'd100);

    // Abort during LOAD, then a fresh sequence from IDLE.
    push("b4_done_restart", mk(3'd6, 5'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1), 1,
         1'b1, 1'b0, 1'b0, 5'b11111);
    push("b4_memrst", mk(3'd1, 5'b11111, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b4_load_abort", mk(3'd2, 5'b0, 5'b11111, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1,
         1'b0, 1'b1);
    push("b4_abort_idle", IDLE_V, 1);
    push("b4_idle_start", IDLE_V, 1, 1'b1, 1'b0, 1'b0, 5'b00110);
    push("b4_memrst2", mk(3'd1, 5'b00110, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b4_load2", mk(3'd2, 5'b0, 5'b00110, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 2);
    push("b4_corerst2", mk(3'd3, 5'b11001, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 3);
    push("b4_run", RUN_V, 2);
    drain(1);
    chk_cnt("b4_count_run2", 1, 32'd2);

    // Asynchronous reset between edges clears outputs without a clock edge.
    #2 rst_n_b = 1'b0;
    #1;
    n_checks++;
    assert (obs(1) === IDLE_V) else begin
      n_err++;
      $error("FAIL b5_async_reset: observed %h expected %h", obs(1), IDLE_V);
    end
    chk_cnt("b5_async_count", 1, 32'd0);
    @(negedge clk);
    rst_n_b = 1'b1;
    push("b5_stay_idle", IDLE_V, 3);
    push("b5_idle_start", IDLE_V, 1, 1'b1, 1'b0, 1'b0, 5'b01000);
    push("b5_memrst", mk(3'd1, 5'b01000, 5'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
